// File: rtl/rca.sv
// rca: 4-bit ripple-carry adder slice.
//
// Ports:
//   a, b  in  4  operand nibbles
//   c0    in  1  carry into bit 0
//   s     out 4  sum nibble
//   c4    out 1  carry out of bit 3
module rca (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c0,
    output logic [3:0] s,
    output logic       c4
);

    logic [4:0] c;

    assign c[0] = c0;

    for (genvar i = 0; i < 4; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign c4 = c[4];

endmodule

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: WIDTH-bit adder that streams the operand pair through
// one 4-bit rca slice, one nibble per clock, LSB nibble first, with the
// inter-nibble carry held in a register.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. The producer holds its payload stable while valid=1 and ready=0;
// ready is decoded from registered state only and never depends on valid.
//
// Ports:
//   clk        in   1      clock, rising edge
//   rst        in   1      asynchronous active-high reset
//   in_valid   in   1      operand pair present
//   in_ready   out  1      block can accept operands (IDLE)
//   a, b       in   WIDTH  operands, sampled on acceptance
//   cin        in   1      carry-in, sampled on acceptance
//   out_valid  out  1      result present (DONE)
//   out_ready  in   1      downstream takes the result
//   sum        out  WIDTH  registered result
//   cout       out  1      carry out of bit WIDTH-1
//   overflow   out  1      signed two's-complement overflow
//   fsm_state  out  2      current FSM state (0 IDLE, 1 BUSY, 2 DONE)
//
// WIDTH must be a multiple of 4 and at least 8.
module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic [1:0]       fsm_state
);

    localparam int NIB = WIDTH / 4;
    localparam int IW  = $clog2(NIB);
    localparam logic [IW-1:0] LAST = IW'(NIB - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] a_r, b_r, work_r, work_next;
    logic             carry_r;
    logic [IW-1:0]    idx;
    logic             last;

    logic [3:0]       nib_a, nib_b, nib_s;
    logic             nib_c4;

    // Nibble selection: idx*4 expressed as a concatenation keeps the index
    // expression width-exact.
    assign nib_a = a_r[{idx, 2'b00} +: 4];
    assign nib_b = b_r[{idx, 2'b00} +: 4];

    rca rca (
        .a  (nib_a),
        .b  (nib_b),
        .c0 (carry_r),
        .s  (nib_s),
        .c4 (nib_c4)
    );

    assign last      = (idx == LAST);
    assign fsm_state = state;

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        work_next  = work_r;
        work_next[{idx, 2'b00} +: 4] = nib_s;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = BUSY;
            end
            BUSY: begin
                if (last) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            a_r      <= '0;
            b_r      <= '0;
            work_r   <= '0;
            carry_r  <= 1'b0;
            idx      <= '0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r     <= a;
                        b_r     <= b;
                        carry_r <= cin;
                        work_r  <= '0;
                        idx     <= '0;
                    end
                end
                BUSY: begin
                    work_r  <= work_next;
                    carry_r <= nib_c4;
                    idx     <= idx + 1'b1;
                    if (last) begin
                        // The final nibble is taken from the slice directly so
                        // the published result includes it on this same edge.
                        sum      <= work_next;
                        cout     <= nib_c4;
                        overflow <= (a_r[WIDTH-1] == b_r[WIDTH-1]) &&
                                    (nib_s[3] != a_r[WIDTH-1]);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder.sv
module tb_nibble_serial_adder;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a, b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         overflow;
    logic [1:0]   fsm_state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    nibble_serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .overflow  (overflow),
        .fsm_state (fsm_state)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one active edge; sample/drive 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accept one operand pair, check the held previous result while busy,
    // the 4-edge latency, the result, and the single-cycle handoff.
    task automatic do_op(input string tag,
                         input logic [W-1:0] va, input logic [W-1:0] vb, input logic vc,
                         input logic [W-1:0] prev_sum,
                         input logic [W-1:0] esum, input logic ecout, input logic eovf);
        int lat;
        check({tag, "_in_ready_idle"}, in_ready, 1);
        in_valid  = 1'b1;
        a         = va;
        b         = vb;
        cin       = vc;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        a        = ~va;
        b        = ~vb;
        cin      = ~vc;
        check({tag, "_in_ready_busy"}, in_ready, 0);
        check({tag, "_sum_held_busy"}, sum, prev_sum);
        lat = 1;
        while (!out_valid && lat < 20) begin
            step();
            if (!out_valid) lat++;
        end
        check({tag, "_latency"}, lat, 4);
        check({tag, "_out_valid"}, out_valid, 1);
        check({tag, "_sum"}, sum, esum);
        check({tag, "_cout"}, cout, ecout);
        check({tag, "_overflow"}, overflow, eovf);
        step();
        check({tag, "_out_valid_drop"}, out_valid, 0);
        check({tag, "_in_ready_back"}, in_ready, 1);
        check({tag, "_sum_hold_idle"}, sum, esum);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        out_ready = 1'b0;

        // Reset with no clock edge seen yet.
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_sum", sum, 16'h0000);
        check("rst_cout", cout, 0);
        check("rst_overflow", overflow, 0);
        check("rst_state", fsm_state, 0);
        #2 rst = 1'b0;
        step();

        // Basic add.
        do_op("basic", 16'h1234, 16'h4321, 1'b0, 16'h0000, 16'h5555, 1'b0, 1'b0);
        // Carry ripples through every nibble.
        do_op("ripple", 16'hFFFF, 16'h0001, 1'b0, 16'h5555, 16'h0000, 1'b1, 1'b0);
        // Signed overflow produced by cin alone.
        do_op("cin_ovf", 16'h7FFF, 16'h0000, 1'b1, 16'h0000, 16'h8000, 1'b0, 1'b1);

        // Backpressure with input isolation.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        a         = 16'h8000;
        b         = 16'h8000;
        cin       = 1'b0;
        step();
        check("bp_accept", in_ready, 0);
        for (int i = 0; i < 4; i++) begin
            a = W'($urandom_range(0, 16'hFFFF));
            b = W'($urandom_range(0, 16'hFFFF));
            step();
        end
        check("bp_out_valid", out_valid, 1);
        check("bp_sum", sum, 16'h0000);
        check("bp_cout", cout, 1);
        check("bp_overflow", overflow, 1);
        for (int i = 0; i < 5; i++) begin
            a   = 16'h1111 + W'(i);
            b   = W'($urandom_range(0, 16'hFFFF));
            cin = ~cin;
            step();
            check("bp_hold_valid", out_valid, 1);
            check("bp_hold_in_ready", in_ready, 0);
            check("bp_hold_sum", sum, 16'h0000);
            check("bp_hold_cout", cout, 1);
            check("bp_hold_ovf", overflow, 1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        check("bp_handoff_drop", out_valid, 0);
        check("bp_handoff_in_ready", in_ready, 1);
        step();
        check("bp_no_second_accept", in_ready, 1);

        // Reset in the middle of BUSY.
        in_valid = 1'b1;
        a        = 16'h1111;
        b        = 16'h2222;
        cin      = 1'b0;
        step();
        in_valid = 1'b0;
        step();
        step();
        check("mid_busy_state", fsm_state, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_sum", sum, 16'h0000);
        check("mid_rst_cout", cout, 0);
        check("mid_rst_overflow", overflow, 0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            check("post_rst_no_valid", out_valid, 0);
            check("post_rst_in_ready", in_ready, 1);
        end
        do_op("after_rst", 16'h0F0F, 16'h0101, 1'b0, 16'h0000, 16'h1010, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute time bound so a stuck DUT can never hang the run.
    initial begin
        #200000;
        $display("FAIL timeout: observed no completion expected completion");
        $fatal(1, "timeout");
    end

endmodule
